// File: rtl/switch_accumulator.sv
// switch_accumulator: debounced slide-switch event accumulator with a bounded
// running total and a sequential double-dabble converter that drives three
// active-low seven-segment digits (hundreds, tens, units).
module switch_accumulator #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MAX_COUNT       = 255,
  parameter bit WRAP            = 1'b0,
  localparam int W              = $clog2(MAX_COUNT + 1)
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic [N_KEYS-1:0] SW,
  input  logic              CLEAR,
  output logic [W-1:0]      COUNT,
  output logic              EVENT,
  output logic              OVF,
  output logic              BUSY,
  output logic [0:6]        HEX2,
  output logic [0:6]        HEX1,
  output logic [0:6]        HEX0
);

  localparam int DW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int STEP_W = $clog2(W + 1);
  localparam logic [DW-1:0]     CNT_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(W - 1);
  localparam logic [W:0]        MAX_EXT   = (W + 1)'(MAX_COUNT);
  localparam logic [W:0]        MOD_EXT   = (W + 1)'(MAX_COUNT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} conv_state_t;

  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;
  logic [N_KEYS-1:0] deb;
  logic [N_KEYS-1:0] deb_q;
  logic [DW-1:0]     deb_cnt [N_KEYS];
  logic [N_KEYS-1:0] edge_vec;
  logic [W:0]        sum;
  logic [W-1:0]      count_next;
  logic              ovf_next;

  conv_state_t       state;
  logic              dirty;
  logic [W-1:0]      bin_sr;
  logic [11:0]       bcd;
  logic [STEP_W-1:0] step;

  // One add-3/shift iteration of double dabble on a three-digit BCD register.
  function automatic logic [11:0] dabble(input logic [11:0] b, input logic in_bit);
    logic [11:0] t;
    t = b;
    for (int d = 0; d < 3; d++) begin
      if (t[4*d +: 4] >= 4'd5) t[4*d +: 4] = t[4*d +: 4] + 4'd3;
    end
    return {t[10:0], in_bit};
  endfunction

  // Active-low segment pattern, index 0 is segment a.
  function automatic logic [0:6] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0001100;
      default: return 7'b1111111;
    endcase
  endfunction

  // Two-flop synchroniser bringing the raw switch levels into the clock domain.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= SW;
      sync2 <= sync1;
    end
  end

  // Per-channel stable counter: accept a new level only after an unbroken run of differing samples.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      deb <= '0;
      for (int k = 0; k < N_KEYS; k++) deb_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < N_KEYS; k++) begin
        if (sync2[k] != deb[k]) begin
          if (deb_cnt[k] == CNT_LAST) begin
            deb[k]     <= sync2[k];
            deb_cnt[k] <= '0;
          end else begin
            deb_cnt[k] <= deb_cnt[k] + DW'(1);
          end
        end else begin
          deb_cnt[k] <= '0;
        end
      end
    end
  end

  // Delayed copy of the debounced levels used for rising-edge detection.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) deb_q <= '0;
    else          deb_q <= deb;
  end

  assign edge_vec = deb & ~deb_q;
  assign sum      = {1'b0, COUNT} + (W + 1)'(edge_vec);

  // Next total: clear dominates, otherwise add the edge vector with saturate or wrap on overflow.
  always_comb begin
    count_next = COUNT;
    ovf_next   = OVF;
    if (CLEAR) begin
      count_next = '0;
      ovf_next   = 1'b0;
    end else if (edge_vec != '0) begin
      if (sum > MAX_EXT) begin
        ovf_next = 1'b1;
        if (WRAP) count_next = W'(sum - MOD_EXT);
        else      count_next = W'(MAX_COUNT);
      end else begin
        count_next = sum[W-1:0];
      end
    end
  end

  // Register the total, the sticky overflow and the event pulse.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      COUNT <= '0;
      OVF   <= 1'b0;
      EVENT <= 1'b0;
    end else begin
      COUNT <= count_next;
      OVF   <= ovf_next;
      EVENT <= |edge_vec;
    end
  end

  // Converter FSM: snapshot the total, run W dabble steps, publish digits, rerun if the total moved meanwhile.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= IDLE;
      dirty  <= 1'b0;
      bin_sr <= '0;
      bcd    <= '0;
      step   <= '0;
      BUSY   <= 1'b0;
      HEX2   <= 7'b0000001;
      HEX1   <= 7'b0000001;
      HEX0   <= 7'b0000001;
    end else begin
      dirty <= (count_next != COUNT) | (dirty & (state != LOAD));
      case (state)
        IDLE: begin
          if (dirty) begin
            state <= LOAD;
            BUSY  <= 1'b1;
          end
        end
        LOAD: begin
          bin_sr <= COUNT;
          bcd    <= '0;
          step   <= '0;
          state  <= SHIFT;
        end
        SHIFT: begin
          bcd    <= dabble(bcd, bin_sr[W-1]);
          bin_sr <= bin_sr << 1;
          if (step == STEP_LAST) begin
            step  <= '0;
            state <= DONE;
          end else begin
            step <= step + STEP_W'(1);
          end
        end
        DONE: begin
          HEX2 <= seg7(bcd[11:8]);
          HEX1 <= seg7(bcd[7:4]);
          HEX0 <= seg7(bcd[3:0]);
          if (dirty) begin
            state <= LOAD;
          end else begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_switch_accumulator.sv
// tb_switch_accumulator: drives a saturating (MAX 255) and a wrapping (MAX 99)
// instance from the same switches and compares both against a reference model
// of the accepted switch levels and the running totals.
module tb_switch_accumulator;

  localparam int N     = 4;
  localparam int D     = 16;
  localparam int MAX_A = 255;
  localparam int MAX_B = 99;
  localparam int HOLD  = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic [N-1:0] sw = '0;

  logic [7:0]   count_a;
  logic [6:0]   count_b;
  logic         event_a, ovf_a, busy_a;
  logic         event_b, ovf_b, busy_b;
  logic [0:6]   hex_a2, hex_a1, hex_a0;
  logic [0:6]   hex_b2, hex_b1, hex_b0;

  logic [0:6] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100};

  logic [N-1:0] level_m;
  int           cnt_a_m, cnt_b_m;
  bit           ovf_a_m, ovf_b_m;
  int           errors = 0;
  int           checks = 0;
  int           ev_a = 0;
  int           ev_b = 0;
  int           busy_cycles;

  always #5 clk = ~clk;

  switch_accumulator #(.N_KEYS(N), .DEBOUNCE_CYCLES(D), .MAX_COUNT(MAX_A), .WRAP(1'b0)) dut_a (
    .CLOCK_50(clk), .RESET_N(rst_n), .SW(sw), .CLEAR(clear),
    .COUNT(count_a), .EVENT(event_a), .OVF(ovf_a), .BUSY(busy_a),
    .HEX2(hex_a2), .HEX1(hex_a1), .HEX0(hex_a0)
  );

  switch_accumulator #(.N_KEYS(N), .DEBOUNCE_CYCLES(D), .MAX_COUNT(MAX_B), .WRAP(1'b1)) dut_b (
    .CLOCK_50(clk), .RESET_N(rst_n), .SW(sw), .CLEAR(clear),
    .COUNT(count_b), .EVENT(event_b), .OVF(ovf_b), .BUSY(busy_b),
    .HEX2(hex_b2), .HEX1(hex_b1), .HEX0(hex_b0)
  );

  // Advance n cycles, landing on the falling edge, and tally event pulses seen.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (event_a === 1'b1) ev_a++;
      if (event_b === 1'b1) ev_b++;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Reference totals: bounded sum, clamp for the saturating unit, modulo for the wrapping unit.
  task automatic modelAdd(input int inc);
    int s;
    if (inc == 0) return;
    s = cnt_a_m + inc;
    if (s > MAX_A) begin
      cnt_a_m = MAX_A;
      ovf_a_m = 1'b1;
    end else begin
      cnt_a_m = s;
    end
    s = cnt_b_m + inc;
    if (s > MAX_B) ovf_b_m = 1'b1;
    cnt_b_m = s % (MAX_B + 1);
  endtask

  task automatic checkDisplay(input string tag, input int value,
                              input logic [0:6] h2, input logic [0:6] h1, input logic [0:6] h0);
    checkOutput({tag, "/hex2"}, 32'(h2), 32'(seg_tab[value / 100]));
    checkOutput({tag, "/hex1"}, 32'(h1), 32'(seg_tab[(value / 10) % 10]));
    checkOutput({tag, "/hex0"}, 32'(h0), 32'(seg_tab[value % 10]));
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, "/count_a"}, 32'(count_a), cnt_a_m);
    checkOutput({tag, "/ovf_a"}, 32'(ovf_a), 32'(ovf_a_m));
    checkOutput({tag, "/busy_a"}, 32'(busy_a), 0);
    checkDisplay({tag, "/a"}, cnt_a_m, hex_a2, hex_a1, hex_a0);
    checkOutput({tag, "/count_b"}, 32'(count_b), cnt_b_m);
    checkOutput({tag, "/ovf_b"}, 32'(ovf_b), 32'(ovf_b_m));
    checkOutput({tag, "/busy_b"}, 32'(busy_b), 0);
    checkDisplay({tag, "/b"}, cnt_b_m, hex_b2, hex_b1, hex_b0);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "/count_a"}, 32'(count_a), 0);
    checkOutput({tag, "/event_a"}, 32'(event_a), 0);
    checkOutput({tag, "/ovf_a"}, 32'(ovf_a), 0);
    checkOutput({tag, "/busy_a"}, 32'(busy_a), 0);
    checkDisplay({tag, "/a"}, 0, hex_a2, hex_a1, hex_a0);
    checkOutput({tag, "/count_b"}, 32'(count_b), 0);
    checkOutput({tag, "/ovf_b"}, 32'(ovf_b), 0);
    checkOutput({tag, "/busy_b"}, 32'(busy_b), 0);
    checkDisplay({tag, "/b"}, 0, hex_b2, hex_b1, hex_b0);
  endtask

  // Hold a new switch pattern long enough to be accepted and displayed; rising bits add their weights.
  task automatic applyStimulus(input logic [N-1:0] pattern, input string tag);
    int a0;
    int b0;
    int inc;
    a0  = ev_a;
    b0  = ev_b;
    inc = 32'(pattern & ~level_m);
    sw  = pattern;
    tick(HOLD);
    level_m = pattern;
    modelAdd(inc);
    checkOutput({tag, "/events_a"}, ev_a - a0, (inc != 0) ? 1 : 0);
    checkOutput({tag, "/events_b"}, ev_b - b0, (inc != 0) ? 1 : 0);
    checkState(tag);
  endtask

  // Flip some switches for fewer than D cycles, then restore; nothing may be counted.
  task automatic applyGlitch(input logic [N-1:0] bits, input int len, input string tag);
    int a0;
    a0 = ev_a;
    sw = level_m ^ bits;
    tick(len);
    sw = level_m;
    tick(HOLD);
    checkOutput({tag, "/events_a"}, ev_a - a0, 0);
    checkState(tag);
  endtask

  task automatic doClear(input string tag);
    clear = 1'b1;
    tick(1);
    clear   = 1'b0;
    cnt_a_m = 0;
    cnt_b_m = 0;
    ovf_a_m = 1'b0;
    ovf_b_m = 1'b0;
    tick(HOLD);
    checkState(tag);
  endtask

  initial begin
    level_m = '0;
    cnt_a_m = 0;
    cnt_b_m = 0;
    ovf_a_m = 1'b0;
    ovf_b_m = 1'b0;

    // Reset values
    tick(3);
    checkReset("reset");
    rst_n = 1'b1;

    // Single SW[1] edge: exact event and display latency
    sw = 4'b0010;
    tick(18);
    checkOutput("lat/event_early", 32'(event_a), 0);
    checkOutput("lat/count_early", 32'(count_a), 0);
    tick(1);
    checkOutput("lat/event_a", 32'(event_a), 1);
    checkOutput("lat/event_b", 32'(event_b), 1);
    checkOutput("lat/count_a", 32'(count_a), 2);
    checkOutput("lat/count_b", 32'(count_b), 2);
    tick(1);
    checkOutput("lat/event_gone", 32'(event_a), 0);
    checkOutput("lat/busy_start", 32'(busy_a), 1);
    tick(9);
    checkOutput("lat/busy_last", 32'(busy_a), 1);
    checkOutput("lat/hex0_old", 32'(hex_a0), 32'(seg_tab[0]));
    tick(1);
    checkOutput("lat/busy_end", 32'(busy_a), 0);
    checkDisplay("lat/a", 2, hex_a2, hex_a1, hex_a0);
    level_m = 4'b0010;
    modelAdd(2);
    tick(2);
    applyStimulus(4'b0000, "fall1");

    // Simultaneous SW[0] and SW[3] edges sum into one event
    applyStimulus(4'b1001, "simul");
    checkOutput("simul/count", 32'(count_a), 11);
    applyStimulus(4'b0000, "fall2");

    // Short pulses, including the longest rejected length
    applyGlitch(4'b0100, 10, "glitch10");
    applyGlitch(4'b0100, D - 1, "glitch15");

    // Build the wrapping unit up to 95, then overflow it with SW[3]
    doClear("clear1");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'b1111, "build_b");
      applyStimulus(4'b0000, "build_b0");
    end
    applyStimulus(4'b0101, "build_b5");
    applyStimulus(4'b0000, "build_b50");
    checkOutput("wrap/pre", 32'(count_b), 95);
    applyStimulus(4'b1000, "wrap");
    checkOutput("wrap/count_b", 32'(count_b), 3);
    checkOutput("wrap/ovf_b", 32'(ovf_b), 1);

    // CLEAR on the same cycle as an SW[0] event
    sw = 4'b1001;
    tick(18);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    checkOutput("clr_evt/event_a", 32'(event_a), 1);
    checkOutput("clr_evt/event_b", 32'(event_b), 1);
    checkOutput("clr_evt/count_a", 32'(count_a), 0);
    checkOutput("clr_evt/ovf_a", 32'(ovf_a), 0);
    checkOutput("clr_evt/count_b", 32'(count_b), 0);
    checkOutput("clr_evt/ovf_b", 32'(ovf_b), 0);
    level_m = 4'b1001;
    cnt_a_m = 0;
    cnt_b_m = 0;
    ovf_a_m = 1'b0;
    ovf_b_m = 1'b0;
    tick(HOLD);
    checkState("clr_evt");
    applyStimulus(4'b0000, "fall3");

    // Saturate the first unit from 250
    for (int i = 0; i < 16; i++) begin
      applyStimulus(4'b1111, "build_a");
      applyStimulus(4'b0000, "build_a0");
    end
    applyStimulus(4'b0010, "build_a2");
    applyStimulus(4'b0000, "build_a20");
    applyStimulus(4'b1000, "build_a8");
    applyStimulus(4'b0000, "build_a80");
    checkOutput("sat/pre", 32'(count_a), 250);
    applyStimulus(4'b1000, "sat");
    checkOutput("sat/count_a", 32'(count_a), 255);
    checkOutput("sat/ovf_a", 32'(ovf_a), 1);
    checkOutput("sat/hex2", 32'(hex_a2), 32'(7'b0010010));
    checkOutput("sat/hex0", 32'(hex_a0), 32'(7'b0100100));
    applyStimulus(4'b0000, "fall4");
    doClear("clear2");

    // Two events three cycles apart: BUSY stays high, display converges on the final sum
    sw = 4'b0001;
    tick(3);
    sw = 4'b0011;
    tick(16);
    busy_cycles = 0;
    repeat (20) begin
      tick(1);
      if (busy_a === 1'b1) busy_cycles++;
    end
    checkOutput("pair/busy_cycles", busy_cycles, 20);
    tick(1);
    level_m = 4'b0011;
    modelAdd(1);
    modelAdd(2);
    checkState("pair");

    // Asynchronous reset in the middle of a conversion
    sw = 4'b0111;
    tick(23);
    checkOutput("midreset/busy_before", 32'(busy_a), 1);
    #2 rst_n = 1'b0;
    #1 checkReset("midreset");
    tick(2);
    rst_n   = 1'b0;
    level_m = '0;
    cnt_a_m = 0;
    cnt_b_m = 0;
    ovf_a_m = 1'b0;
    ovf_b_m = 1'b0;
    rst_n   = 1'b1;
    applyStimulus(4'b0111, "release_high");

    // Randomised mix of level changes, glitches and clears
    for (int i = 0; i < 30; i++) begin
      int r;
      r = int'($urandom_range(0, 7));
      if (r == 0) doClear("rnd_clear");
      else if (r == 1) applyGlitch(N'($urandom_range(1, 15)), int'($urandom_range(1, D - 1)), "rnd_glitch");
      else applyStimulus(N'($urandom_range(0, 15)), "rnd_step");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
